// File: rtl/word_packer_if.sv
// Handshake bundle between a single-word producer, the word packer and a
// consumer of the packed NUM_SLOTS*WIDTH bus.
interface word_packer_if #(
    parameter int WIDTH     = 32,
    parameter int NUM_SLOTS = 2,
    parameter int SIZE_SEL  = $clog2(NUM_SLOTS)
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_data;
    logic                       in_last;
    logic [SIZE_SEL-1:0]        sel;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_SLOTS*WIDTH-1:0] out_data;
    logic [SIZE_SEL:0]          out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, sel, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, sel, out_valid, out_data, out_count
    );
endinterface

// File: rtl/word_packer.sv
// Gathers one word per accept into slot SEL of a flat bus and presents the
// group downstream when the bus fills or a word is flagged last.
module word_packer #(
    parameter int WIDTH     = 32,
    parameter int NUM_SLOTS = 2,
    parameter int SIZE_SEL  = $clog2(NUM_SLOTS)
) (
    input logic           clk,
    input logic           rst_n,
    word_packer_if.slave  bus
);
    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [SIZE_SEL-1:0] SEL_ONE  = SIZE_SEL'(1);
    localparam logic [SIZE_SEL-1:0] SEL_LAST = SIZE_SEL'(NUM_SLOTS - 1);
    localparam logic [SIZE_SEL:0]   CNT_ONE  = (SIZE_SEL + 1)'(1);

    state_t                     state_q;
    logic [SIZE_SEL-1:0]        sel_q;
    logic [SIZE_SEL:0]          count_q;
    logic [NUM_SLOTS*WIDTH-1:0] data_q;
    logic                       in_ready_w;
    logic                       accept;

    // Reset gating is the only combinational term on the ready path.
    assign in_ready_w    = (state_q == FILL) && rst_n;
    assign accept        = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_count = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            sel_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_SLOTS; k++) begin
                            if (sel_q == SIZE_SEL'(k)) begin
                                data_q[k*WIDTH +: WIDTH] <= bus.in_data;
                            end
                        end
                        sel_q   <= sel_q + SEL_ONE;
                        count_q <= count_q + CNT_ONE;
                        // The last slot always closes the group, so SEL never wraps mid-group.
                        if ((sel_q == SEL_LAST) || bus.in_last) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        data_q  <= '0;
                        sel_q   <= '0;
                        count_q <= '0;
                        state_q <= FILL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer with WIDTH=8, NUM_SLOTS=4: directed
// scenarios plus a randomized stream scored against a transaction-level model.
module tb_word_packer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  n;
    } grp_t;

    word_packer_if #(.WIDTH(8), .NUM_SLOTS(4)) bus();

    word_packer #(.WIDTH(8), .NUM_SLOTS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed value of a list of words: word i lands at bits [8i+7:8i].
    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] r;
        r = '0;
        foreach (q[i]) r = r | (32'(q[i]) << (8 * i));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
            checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
            checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
            checks++; if (bus.out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", bus.out_count); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_full_group();
        logic [7:0] w [4];
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = w[i]; bus.in_last = 1'b0;
            #1;
            checks++; if (bus.sel !== 2'(i)) begin errors++; $display("FAIL full_sel got=%0d exp=%0d", bus.sel, i); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got=%b exp=1", bus.in_ready); end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h44332211) begin errors++; $display("FAIL full_out_data got=%h exp=44332211", bus.out_data); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL full_out_count got=%0d exp=4", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_hold_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_release_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL full_release_out_data got=%h exp=0", bus.out_data); end
    endtask

    task automatic test_early_close();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_last = 1'b0;
        tick();
        bus.in_data = 8'hBB; bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL early_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0000BBAA) begin errors++; $display("FAIL early_out_data got=%h exp=0000bbaa", bus.out_data); end
        checks++; if (bus.out_count !== 3'd2) begin errors++; $display("FAIL early_out_count got=%0d exp=2", bus.out_count); end
        checks++; if (bus.sel !== 2'd2) begin errors++; $display("FAIL early_hold_sel got=%0d exp=2", bus.sel); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hCC; bus.in_last = 1'b1;
        #1;
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL early_next_sel got=%0d exp=0", bus.sel); end
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        #1;
        checks++; if (bus.out_data !== 32'h000000CC) begin errors++; $display("FAIL single_out_data got=%h exp=000000cc", bus.out_data); end
        checks++; if (bus.out_count !== 3'd1) begin errors++; $display("FAIL single_out_count got=%0d exp=1", bus.out_count); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0]  q[$];
        logic [31:0] exp;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.in_last = 1'b0;
            q.push_back(bus.in_data);
            tick();
        end
        exp = pack(q);
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
            checks++; if (bus.out_data !== exp) begin errors++; $display("FAIL bp_out_data got=%h exp=%h", bus.out_data, exp); end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL bp_release_sel got=%0d exp=0", bus.sel); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_data !== 32'h000000EE) begin errors++; $display("FAIL bp_ee_slot0 got=%h exp=000000ee", bus.out_data); end
        checks++; if (bus.sel !== 2'd1) begin errors++; $display("FAIL bp_ee_sel got=%0d exp=1", bus.sel); end
        bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_last = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stalled_producer();
        logic       v [7];
        logic [7:0] next;
        int         acc;
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        next = 8'h01; acc = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = v[i]; bus.in_data = v[i] ? next : 8'hFF; bus.in_last = 1'b0;
            #1;
            checks++; if (bus.sel !== 2'(acc)) begin errors++; $display("FAIL stall_sel step=%0d got=%0d exp=%0d", i, bus.sel, acc); end
            tick();
            if (v[i]) begin next++; acc++; end
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_data !== 32'h04030201) begin errors++; $display("FAIL stall_out_data got=%h exp=04030201", bus.out_data); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL stall_out_count got=%0d exp=4", bus.out_count); end
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_last = 1'b0;
        tick();
        bus.in_data = 8'h66;
        tick();
        bus.in_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL mrst_out_data got=%h exp=0", bus.out_data); end
        checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL mrst_sel got=%0d exp=0", bus.sel); end
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'h77 + 8'(i);
            #1;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_group step=%0d got=%b exp=0", i, bus.out_valid); end
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_data !== 32'h7A797877) begin errors++; $display("FAIL mrst_out_data_after got=%h exp=7a797877", bus.out_data); end
        checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL mrst_out_count_after got=%0d exp=4", bus.out_count); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] pend[$];
        grp_t       expq[$];
        grp_t       g;
        logic       holding;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_data   = 8'($urandom);
            bus.in_last   = ($urandom % 5) == 0;
            bus.out_ready = ($urandom % 3) != 0;
            holding = (expq.size() != 0);
            #1;
            checks++; if (bus.in_ready !== !holding) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, !holding); end
            checks++; if (bus.out_valid !== holding) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, bus.out_valid, holding); end
            if (holding) begin
                checks++; if (bus.out_data !== expq[0].d) begin errors++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", c, bus.out_data, expq[0].d); end
                checks++; if (bus.out_count !== expq[0].n) begin errors++; $display("FAIL rnd_out_count cyc=%0d got=%0d exp=%0d", c, bus.out_count, expq[0].n); end
            end else begin
                checks++; if (bus.sel !== 2'(pend.size())) begin errors++; $display("FAIL rnd_sel cyc=%0d got=%0d exp=%0d", c, bus.sel, pend.size()); end
                checks++; if (bus.out_data !== pack(pend)) begin errors++; $display("FAIL rnd_partial cyc=%0d got=%h exp=%h", c, bus.out_data, pack(pend)); end
            end
            if (holding) begin
                if (bus.out_ready) void'(expq.pop_front());
            end else if (bus.in_valid) begin
                pend.push_back(bus.in_data);
                if (pend.size() == 4 || bus.in_last) begin
                    g.d = pack(pend);
                    g.n = 3'(pend.size());
                    expq.push_back(g);
                    pend.delete();
                end
            end
            tick();
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_full_group();
        test_early_close();
        test_backpressure();
        test_stalled_producer();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
